reg_bank8: RTL and testbench
============================

// Module: reg_bank8
// PURPOSE
//  Eight 8-bit general registers R0..R7 directly upstream of the 8:1 operand mux.
//  Outputs r0..r7 wire straight to mux data inputs d0..d7; registered sel_q drives the mux select.
//  Per-cycle register op (load/increment/clear) on one addressed register.
//  Also provides a carry flag and a one-cycle write-done pulse for the control unit.
// PARAMETERS
//  WIDTH      8        data width of each register (processor datapath is 8)
//  NREG       8        number of registers; fixed at 8 to match 3-bit select
//  RST_VAL    8'h00    reset/clear value of every register
// PORTS
//  clk        in   1      rising-edge clock
//  reset      in   1      asynchronous, active-high reset
//  op         in   2      00 NOP, 01 LOAD, 10 INC, 11 CLR
//  waddr      in   3      target register for op
//  din        in   8      LOAD data
//  sel_we     in   1      capture sel_in into sel_q this cycle
//  sel_in     in   3      next mux select
//  r0..r7     out  8      current register contents (to mux d0..d7)
//  sel_q      out  3      registered mux select (to mux s)
//  carry      out  1      sticky carry from INC wrap
//  wr_done    out  1      1-cycle pulse after any non-NOP op commits
// BEHAVIOUR
//  Reset (async, active-high): r0..r7=RST_VAL, sel_q=0, carry=0, wr_done=0;
//   holds while reset=1, ops and sel_we ignored; first op is accepted on the first edge after deassert.
//  All state updates on rising clk; outputs are flop outputs (no comb path in->out).
//  LOAD: R[waddr] <= din; visible on r<waddr> the cycle after the edge (1-cycle latency).
//  INC: R[waddr] <= R[waddr]+1 mod 256; 8'hFF -> 8'h00 and carry <= 1.
//   INC with no wrap leaves carry unchanged (sticky).
//  CLR: R[waddr] <= RST_VAL and carry <= 0 (the only non-reset way to clear carry).
//  NOP: no register change; wr_done <= 0.
//  wr_done <= 1 on the edge committing LOAD/INC/CLR, else 0; back-to-back ops hold it high.
//  Only R[waddr] changes per cycle; other registers hold.
//  sel_we=1: sel_q <= sel_in; else hold. Independent of op; both may occur same cycle.
//  Same-cycle op on Rk and sel_in=k: mux sees the new select and the new Rk value together next cycle.
//  Reads never bypass: r<k> shows pre-edge value during the write cycle.
//  Arithmetic is unsigned, WIDTH bits; carry not added into data.
// TESTING
//  Reset mid-run: LOAD R3=8'h5A, assert reset between edges -> r3=00, sel_q=0, carry=0 immediately (async).
//  LOAD all: LOAD Rk=8'h10+k for k=0..7 -> r0..r7 = 10..17; wr_done high 8 cycles, then 0 on NOP.
//  INC wrap: LOAD R5=FE, INC R5 x2 -> r5=FF (carry 0), then 00 (carry 1); INC R5 again -> 01, carry stays 1.
//  CLR: with carry=1, CLR R5 -> r5=00, carry=0; other registers unchanged.
//  Select: sel_we=1 sel_in=6 with LOAD R6=8'hC3 same cycle -> next cycle sel_q=6, r6=C3.
//  NOP hold: op=00 for 10 cycles with random waddr/din -> no register, carry or sel_q change; wr_done=0.

Source files
------------

// File: rtl/reg_bank8.sv
`default_nettype none
// ============================================================================
// Module   : reg_bank8
// Purpose  : Eight-entry general register file feeding the 8:1 operand mux,
//            with registered mux select, sticky INC carry and write-done pulse.
// Revision : 1.0 - initial release
// ============================================================================
module reg_bank8 #(
    parameter int                WIDTH   = 8,
    parameter int                NREG    = 8,
    parameter logic [WIDTH-1:0]  RST_VAL = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        op,
    input  logic [2:0]        waddr,
    input  logic [WIDTH-1:0]  din,
    input  logic              sel_we,
    input  logic [2:0]        sel_in,
    output logic [WIDTH-1:0]  r0,
    output logic [WIDTH-1:0]  r1,
    output logic [WIDTH-1:0]  r2,
    output logic [WIDTH-1:0]  r3,
    output logic [WIDTH-1:0]  r4,
    output logic [WIDTH-1:0]  r5,
    output logic [WIDTH-1:0]  r6,
    output logic [WIDTH-1:0]  r7,
    output logic [2:0]        sel_q,
    output logic              carry,
    output logic              wr_done
);

    localparam logic [1:0]   c_OP_NOP  = 2'b00;
    localparam logic [1:0]   c_OP_LOAD = 2'b01;
    localparam logic [1:0]   c_OP_INC  = 2'b10;
    localparam logic [1:0]   c_OP_CLR  = 2'b11;
    localparam logic [WIDTH:0] c_ONE   = {{WIDTH{1'b0}}, 1'b1};

    logic [WIDTH-1:0] r_regs [NREG];
    logic [2:0]       r_sel_q;
    logic             r_carry;
    logic             r_wr_done;

    // Extra MSB of the sum is the wrap-out used to set the sticky carry.
    logic [WIDTH:0]   w_inc_sum;

    assign w_inc_sum = {1'b0, r_regs[waddr]} + c_ONE;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) begin
                r_regs[i] <= RST_VAL;
            end
            r_carry   <= 1'b0;
            r_wr_done <= 1'b0;
        end else begin
            r_wr_done <= (op != c_OP_NOP);
            case (op)
                c_OP_LOAD: r_regs[waddr] <= din;
                c_OP_INC: begin
                    r_regs[waddr] <= w_inc_sum[WIDTH-1:0];
                    if (w_inc_sum[WIDTH]) begin
                        r_carry <= 1'b1;
                    end
                end
                c_OP_CLR: begin
                    r_regs[waddr] <= RST_VAL;
                    r_carry       <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // Select register is independent of the op path so both can commit together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sel_q <= 3'd0;
        end else if (sel_we) begin
            r_sel_q <= sel_in;
        end
    end

    assign r0      = r_regs[0];
    assign r1      = r_regs[1];
    assign r2      = r_regs[2];
    assign r3      = r_regs[3];
    assign r4      = r_regs[4];
    assign r5      = r_regs[5];
    assign r6      = r_regs[6];
    assign r7      = r_regs[7];
    assign sel_q   = r_sel_q;
    assign carry   = r_carry;
    assign wr_done = r_wr_done;

endmodule
`default_nettype wire

// File: tb/tb_reg_bank8.sv
`default_nettype none
// ============================================================================
// Module   : tb_reg_bank8
// Purpose  : Directed plus random stimulus for reg_bank8 against a
//            behavioural register-file model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_reg_bank8;

    logic       clk;
    logic       reset;
    logic [1:0] op;
    logic [2:0] waddr;
    logic [7:0] din;
    logic       sel_we;
    logic [2:0] sel_in;
    logic [7:0] r0, r1, r2, r3, r4, r5, r6, r7;
    logic [2:0] sel_q;
    logic       carry;
    logic       wr_done;

    int checks;
    int failures;

    int m_reg [8];
    int m_sel;
    int m_carry;
    int m_wd;

    reg_bank8 dut (
        .clk     (clk),
        .reset   (reset),
        .op      (op),
        .waddr   (waddr),
        .din     (din),
        .sel_we  (sel_we),
        .sel_in  (sel_in),
        .r0      (r0),
        .r1      (r1),
        .r2      (r2),
        .r3      (r3),
        .r4      (r4),
        .r5      (r5),
        .r6      (r6),
        .r7      (r7),
        .sel_q   (sel_q),
        .carry   (carry),
        .wr_done (wr_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] dut_r(input int k);
        case (k)
            0: return r0;
            1: return r1;
            2: return r2;
            3: return r3;
            4: return r4;
            5: return r5;
            6: return r6;
            default: return r7;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        for (int k = 0; k < 8; k++) begin
            check($sformatf("%s_r%0d", tag, k), {24'd0, dut_r(k)}, m_reg[k]);
        end
        check({tag, "_sel_q"},   {29'd0, sel_q},   m_sel);
        check({tag, "_carry"},   {31'd0, carry},   m_carry);
        check({tag, "_wr_done"}, {31'd0, wr_done}, m_wd);
    endtask

    task automatic model_reset();
        for (int k = 0; k < 8; k++) m_reg[k] = 0;
        m_sel   = 0;
        m_carry = 0;
        m_wd    = 0;
    endtask

    // One clock of stimulus: the pre-edge check confirms no bypass/comb path.
    task automatic step(input string tag, input int o, input int a, input int d,
                        input int swe, input int si);
        @(negedge clk);
        op     = o[1:0];
        waddr  = a[2:0];
        din    = d[7:0];
        sel_we = swe[0];
        sel_in = si[2:0];
        #1 check_all({tag, "_pre"});
        @(posedge clk);
        case (o)
            1: m_reg[a] = d;
            2: begin
                if (m_reg[a] == 255) m_carry = 1;
                m_reg[a] = (m_reg[a] + 1) % 256;
            end
            3: begin
                m_reg[a] = 0;
                m_carry  = 0;
            end
            default: ;
        endcase
        m_wd = (o != 0) ? 1 : 0;
        if (swe != 0) m_sel = si;
        #1 check_all(tag);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        op       = 2'b00;
        waddr    = 3'd0;
        din      = 8'h00;
        sel_we   = 1'b0;
        sel_in   = 3'd0;
        model_reset();

        // Reset held across edges with live ops must be ignored.
        @(negedge clk);
        op = 2'b01; waddr = 3'd2; din = 8'hAA; sel_we = 1'b1; sel_in = 3'd4;
        @(posedge clk);
        #1 check_all("reset_hold");
        @(negedge clk);
        reset = 1'b0;
        op = 2'b00; sel_we = 1'b0;

        // Load all registers; wr_done stays high throughout.
        for (int k = 0; k < 8; k++) step("load_all", 1, k, 8'h10 + k, 0, 0);
        step("load_all_nop", 0, 0, 0, 0, 0);

        // INC wrap and sticky carry.
        step("inc_ld", 1, 5, 8'hFE, 0, 0);
        step("inc_ff", 2, 5, 0, 0, 0);
        step("inc_wrap", 2, 5, 0, 0, 0);
        step("inc_sticky", 2, 5, 0, 0, 0);

        // CLR clears data and carry only for the target.
        step("clr", 3, 5, 0, 0, 0);

        // Same-cycle select and load of the selected register.
        step("sel_load", 1, 6, 8'hC3, 1, 6);

        // NOP hold with random address/data.
        for (int i = 0; i < 10; i++) step("nop_hold", 0, $urandom_range(0, 7), $urandom_range(0, 255), 0, 0);

        // Random traffic.
        for (int i = 0; i < 300; i++) begin
            step("rand", $urandom_range(0, 3), $urandom_range(0, 7),
                 ($urandom_range(0, 3) == 0) ? 8'hFF : $urandom_range(0, 255),
                 $urandom_range(0, 1), $urandom_range(0, 7));
        end

        // Asynchronous reset mid-cycle with non-trivial state.
        step("pre_rst_sel", 0, 0, 0, 1, 5);
        step("pre_rst_ld", 1, 0, 8'hFF, 0, 0);
        step("pre_rst_inc", 2, 0, 0, 0, 0);
        step("pre_rst_r3", 1, 3, 8'h5A, 0, 0);
        #2 reset = 1'b1;
        #1;
        model_reset();
        check("async_r3", {24'd0, r3}, 0);
        check("async_sel_q", {29'd0, sel_q}, 0);
        check("async_carry", {31'd0, carry}, 0);
        check("async_wr_done", {31'd0, wr_done}, 0);
        check_all("async_rst");
        @(negedge clk);
        reset = 1'b0;
        op = 2'b00; sel_we = 1'b0;
        step("post_rst_ld", 1, 7, 8'h3C, 1, 7);
        step("post_rst_nop", 0, 7, 8'h00, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
